// File: rtl/sync_debounce_if.sv
// sync_debounce_if: level input, glitch clear and debounced outputs.
// The master side drives din/clr_glitch; the slave side is the debouncer.
interface sync_debounce_if #(
    parameter int unsigned GLITCH_WIDTH = 8
) ();
    logic                    din;
    logic                    clr_glitch;
    logic                    dout;
    logic                    busy;
    logic                    rise;
    logic                    fall;
    logic [GLITCH_WIDTH-1:0] glitch_cnt;

    modport master (
        output din,
        output clr_glitch,
        input  dout,
        input  busy,
        input  rise,
        input  fall,
        input  glitch_cnt
    );

    modport slave (
        input  din,
        input  clr_glitch,
        output dout,
        output busy,
        output rise,
        output fall,
        output glitch_cnt
    );
endinterface

// File: rtl/sync_debounce.sv
// sync_debounce: four-state debouncer with saturating glitch counter.
// Define SYNC_DEBOUNCE_EDGE_EN to build the rise/fall edge pulse registers.
module sync_debounce #(
    parameter int unsigned DEBOUNCE_CNT = 1000,
    parameter int unsigned CNT_WIDTH    = 16,
    parameter logic        RESET_VAL    = 1'b0,
    parameter int unsigned GLITCH_WIDTH = 8
) (
    input  logic            clk,
    input  logic            resetn,
    sync_debounce_if.slave  bus
);

    typedef enum logic [1:0] {
        STABLE_LO = 2'b00,
        CHECK_HI  = 2'b01,
        STABLE_HI = 2'b11,
        CHECK_LO  = 2'b10
    } state_e;

    localparam state_e RST_STATE = RESET_VAL ? STABLE_HI : STABLE_LO;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CNT - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [GLITCH_WIDTH-1:0] G_ONE = GLITCH_WIDTH'(1);
    localparam bit SINGLE = (DEBOUNCE_CNT == 1);

    state_e                  state_q, state_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic                    glitch_evt;
    logic [GLITCH_WIDTH-1:0] glitch_q, glitch_d;
    logic                    dout_q, dout_d;
    logic                    busy_q, busy_d;

    // State and stability counter registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= RST_STATE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: qualify a differing din over DEBOUNCE_CNT edges
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        glitch_evt = 1'b0;
        unique case (state_q)
            STABLE_LO: begin
                cnt_d = '0;
                if (bus.din) begin
                    if (SINGLE) begin
                        state_d = STABLE_HI;
                    end else begin
                        state_d = CHECK_HI;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            CHECK_HI: begin
                if (!bus.din) begin
                    state_d    = STABLE_LO;
                    cnt_d      = '0;
                    glitch_evt = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            STABLE_HI: begin
                cnt_d = '0;
                if (!bus.din) begin
                    if (SINGLE) begin
                        state_d = STABLE_LO;
                    end else begin
                        state_d = CHECK_LO;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            CHECK_LO: begin
                if (bus.din) begin
                    state_d    = STABLE_HI;
                    cnt_d      = '0;
                    glitch_evt = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = RST_STATE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output decode from the next state so outputs register with it
    always_comb begin
        dout_d = (state_d == STABLE_HI) || (state_d == CHECK_LO);
        busy_d = (state_d == CHECK_HI) || (state_d == CHECK_LO);
    end

    // Registered level and busy outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dout_q <= RESET_VAL;
            busy_q <= 1'b0;
        end else begin
            dout_q <= dout_d;
            busy_q <= busy_d;
        end
    end

    // Glitch counter next value: clear wins, then saturating increment
    always_comb begin
        glitch_d = glitch_q;
        if (bus.clr_glitch) begin
            glitch_d = '0;
        end else if (glitch_evt && (glitch_q != '1)) begin
            glitch_d = glitch_q + G_ONE;
        end
    end

    // Glitch counter register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            glitch_q <= '0;
        end else begin
            glitch_q <= glitch_d;
        end
    end

`ifdef SYNC_DEBOUNCE_EDGE_EN
    logic rise_q, rise_d;
    logic fall_q, fall_d;

    // Edge pulses line up with the dout register update
    always_comb begin
        rise_d = dout_d & ~dout_q;
        fall_d = ~dout_d & dout_q;
    end

    // Edge pulse registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign bus.rise = rise_q;
    assign bus.fall = fall_q;

    a_edge_excl: assert property (
        @(posedge clk) disable iff (!resetn) !(rise_q && fall_q));
`else
    assign bus.rise = 1'b0;
    assign bus.fall = 1'b0;
`endif

    assign bus.dout       = dout_q;
    assign bus.busy       = busy_q;
    assign bus.glitch_cnt = glitch_q;

    a_cnt_bound: assert property (
        @(posedge clk) disable iff (!resetn) cnt_q <= CNT_LAST);

    a_busy_state: assert property (
        @(posedge clk) disable iff (!resetn)
        busy_q == ((state_q == CHECK_HI) || (state_q == CHECK_LO)));

endmodule

// File: doc/sync_debounce.md
SYNC_DEBOUNCE -- requirements
Module: sync_debounce

Interface
REQ-001 SHALL have parameter DEBOUNCE_CNT, default 1000: consecutive din samples required to accept a level change; legal range 1 to 2**CNT_WIDTH-1.
REQ-002 SHALL have parameter CNT_WIDTH, default 16: width of the stability counter.
REQ-003 SHALL have parameter RESET_VAL, default 1'b0: level of dout after reset.
REQ-004 SHALL have parameter GLITCH_WIDTH, default 8: width of the glitch counter.
REQ-005 clk  input  1  single clock; all logic is rising-edge.
REQ-006 resetn  input  1  reset, asynchronous assert, active-low.
REQ-007 din  input  1  level already synchronized into clk by an upstream data_sync; no metastability handling inside this block.
REQ-008 clr_glitch  input  1  synchronous clear of glitch_cnt.
REQ-009 dout  output  1  debounced level, registered.
REQ-010 busy  output  1  high while a candidate level change is being qualified.
REQ-011 rise  output  1  one-cycle pulse when dout goes 0->1.
REQ-012 fall  output  1  one-cycle pulse when dout goes 1->0.
REQ-013 glitch_cnt  output  GLITCH_WIDTH  saturating count of rejected level changes.

Function
REQ-014 SHALL implement FSM states STABLE_LO, CHECK_HI, STABLE_HI, CHECK_LO; dout is 1 in STABLE_HI and CHECK_LO, and 0 otherwise.
REQ-015 STABLE_x: din equal to dout -> stay, cnt=0; din differing from dout -> go to CHECK state with cnt=1.
REQ-016 CHECK_x: din differing from dout and cnt==DEBOUNCE_CNT-1 -> go to the opposite STABLE state, dout toggles, cnt=0.
REQ-017 CHECK_x: din differing from dout and cnt below DEBOUNCE_CNT-1 -> cnt increments by 1.
REQ-018 CHECK_x: din equal to dout -> return to the originating STABLE state, cnt=0, glitch_cnt increments by 1.
REQ-019 Latency: dout updates on the clock edge at which the new din level has been sampled on DEBOUNCE_CNT consecutive edges.
REQ-020 DEBOUNCE_CNT==1: CHECK states are never entered; dout follows din with 1-cycle latency; busy stays 0; glitch_cnt never increments.
REQ-021 busy SHALL be 1 exactly while in CHECK_HI or CHECK_LO.
REQ-022 cnt SHALL never exceed DEBOUNCE_CNT-1; no wrap-around.
REQ-023 glitch_cnt saturates at all-ones.
REQ-024 clr_glitch takes priority over a simultaneous glitch increment; glitch_cnt becomes 0 on the next edge.
REQ-025 rise and fall SHALL be registered and asserted in the same cycle in which dout changes; they are never high together.

Reset
REQ-026 Whenever resetn is low, immediately: state = STABLE_HI if RESET_VAL=1 else STABLE_LO; dout=RESET_VAL; cnt=0; busy=0; rise=0; fall=0; glitch_cnt=0.
REQ-027 After resetn deasserts, a din level that differs from RESET_VAL SHALL be qualified per REQ-015..019 and SHALL produce the corresponding rise/fall pulse.
REQ-028 Reset asserted mid-CHECK SHALL abort qualification without a glitch_cnt increment.

Configuration
REQ-029 Macro SYNC_DEBOUNCE_EDGE_EN defined: rise/fall are generated per REQ-025.
REQ-030 Macro SYNC_DEBOUNCE_EDGE_EN undefined: rise and fall are tied to 0, no edge registers are instantiated, and all other behaviour is unchanged.

Verification
REQ-031 DEBOUNCE_CNT=4, RESET_VAL=0, din 0->1 held: dout=1, busy=0, and rise=1 for one cycle, all at the 4th edge sampling din=1; busy=1 at edges 1-3.
REQ-032 DEBOUNCE_CNT=4, din=1 for 3 edges then 0: dout stays 0, busy drops, glitch_cnt=1; repeat 300 times with GLITCH_WIDTH=8 -> glitch_cnt=255.
REQ-033 DEBOUNCE_CNT=1, din toggling every cycle: dout equals din delayed 1 cycle, rise/fall alternate, busy=0.
REQ-034 resetn pulsed low at cnt=2 of CHECK_HI: outputs immediately at reset values; after release with din=1, dout=1 four edges later and glitch_cnt=0.
REQ-035 RESET_VAL=1, din=0 at reset release, DEBOUNCE_CNT=4: fall pulses and dout=0 at the 4th edge; with SYNC_DEBOUNCE_EDGE_EN undefined, rise=fall=0 throughout.
REQ-036 clr_glitch=1 in the same cycle as a glitch abort: glitch_cnt=0 on the next edge.
